// File: rtl/ras_stack_ctrl.sv
// Return-address stack controller: drives a dual-port RAM as a circular stack,
// with one speculative pointer/count checkpoint for mispredict recovery.
module ras_stack_ctrl #(
    parameter int DEPTH = 1024,
    parameter int ADDR  = 10,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_valid,
    output logic             pop_ready,
    output logic             pop_rvalid,
    output logic [WIDTH-1:0] pop_rdata,
    output logic             pop_rerr,
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
    output logic             empty,
    output logic             full,
    output logic [ADDR:0]    count,
    output logic             bram_ena,
    output logic             bram_wea,
    output logic [ADDR-1:0]  bram_addra,
    output logic [WIDTH-1:0] bram_dia,
    output logic             bram_enb,
    output logic             bram_web,
    output logic [ADDR-1:0]  bram_addrb,
    output logic [WIDTH-1:0] bram_dib,
    input  logic [WIDTH-1:0] bram_dob
);

    localparam logic [ADDR:0]   DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0]   ONE_C   = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] ONE_A   = ADDR'(1);

    logic [ADDR-1:0] ptr, ptr_nxt, ckpt_ptr;
    logic [ADDR:0]   cnt, cnt_nxt, ckpt_cnt;
    logic            pop_acc, pop_hit, push_acc;
    logic            pop_vld_p1, pop_err_p1;

    // Occupancy saturates at DEPTH: a push onto a full stack overwrites the oldest slot.
    function automatic logic [ADDR:0] sat_inc(input logic [ADDR:0] c);
        return (c == DEPTH_C) ? c : c + ONE_C;
    endfunction

    assign pop_ready  = !rst && !ckpt_restore;
    assign push_ready = !rst && !ckpt_restore && !pop_valid;
    assign pop_acc    = pop_valid && pop_ready;
    assign pop_hit    = pop_acc && (cnt != '0);
    assign push_acc   = push_valid && push_ready;

    assign bram_ena   = push_acc;
    assign bram_wea   = push_acc;
    assign bram_addra = ptr;
    assign bram_dia   = push_data;
    assign bram_enb   = pop_hit;
    assign bram_web   = 1'b0;
    assign bram_addrb = ptr - ONE_A;
    assign bram_dib   = '0;

    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        if (ckpt_restore) begin
            ptr_nxt = ckpt_ptr;
            cnt_nxt = ckpt_cnt;
        end else if (pop_hit) begin
            ptr_nxt = ptr - ONE_A;
            cnt_nxt = cnt - ONE_C;
        end else if (push_acc) begin
            ptr_nxt = ptr + ONE_A;
            cnt_nxt = sat_inc(cnt);
        end
    end

    // Stage p0 -> p1: pointer state, checkpoint and pop-result tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            cnt        <= '0;
            ckpt_ptr   <= '0;
            ckpt_cnt   <= '0;
            pop_vld_p1 <= 1'b0;
            pop_err_p1 <= 1'b0;
        end else begin
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            pop_vld_p1 <= pop_acc;
            pop_err_p1 <= pop_acc && (cnt == '0);
            // The checkpoint records the post-update state so it includes this cycle's op.
            if (ckpt_save && !ckpt_restore) begin
                ckpt_ptr <= ptr_nxt;
                ckpt_cnt <= cnt_nxt;
            end
        end
    end

    // Stage p1: RAM read data arrives registered; gate it with the tracked result flags.
    assign pop_rvalid = pop_vld_p1;
    assign pop_rerr   = pop_err_p1;
    assign pop_rdata  = (pop_vld_p1 && !pop_err_p1) ? bram_dob : '0;

    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);
    assign count = cnt;

endmodule
